// File: rtl/knap_pkg.sv
// Shared types and constants for the knapsack sweep controller and its checker.
// The limit constants and knap_fits() describe the checker's acceptance rule.
package knap_pkg;

    localparam int KNAP_N_ITEMS    = 15;
    localparam int KNAP_MIN_VALUE  = 120;
    localparam int KNAP_MAX_WEIGHT = 60;
    localparam int KNAP_MAX_VOLUME = 60;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } scan_state_e;

    typedef struct packed {
        logic                    issued;
        logic [KNAP_N_ITEMS-1:0] mask;
    } knap_tag_t;

    function automatic logic knap_fits(input int value, input int weight, input int volume);
        return (value >= KNAP_MIN_VALUE) && (weight <= KNAP_MAX_WEIGHT) &&
               (volume <= KNAP_MAX_VOLUME);
    endfunction

endpackage

// File: rtl/knap_scan_ctrl_if.sv
// Host control/status and checker-facing signals of the sweep controller.
// The controller uses the slave modport; the host/checker side uses master.
interface knap_scan_ctrl_if
    import knap_pkg::*;
#(
    parameter int N_ITEMS = KNAP_N_ITEMS,
    parameter int CNT_W   = 16
);
    logic               start;
    logic               abort;
    logic               stop_on_first;
    logic               valid_in;
    logic [N_ITEMS-1:0] cand;
    logic               busy;
    logic               done;
    logic               aborted;
    logic               found;
    logic [N_ITEMS-1:0] first_mask;
    logic [N_ITEMS-1:0] last_mask;
    logic [CNT_W-1:0]   hit_count;

    modport master (
        output start, abort, stop_on_first, valid_in,
        input  cand, busy, done, aborted, found, first_mask, last_mask, hit_count
    );

    modport slave (
        input  start, abort, stop_on_first, valid_in,
        output cand, busy, done, aborted, found, first_mask, last_mask, hit_count
    );

endinterface

// File: rtl/knap_tag_pipe.sv
// Delay line that carries (issued, mask) tags alongside the checker pipeline so a
// returning valid can be matched to the mask that produced it. LAT=0 is a wire.
module knap_tag_pipe
    import knap_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_flush,
    input  knap_tag_t i_tag,
    output knap_tag_t o_tag
);

    generate
        if (LAT == 0) begin : g_wire
            logic w_unused_ok;
            assign w_unused_ok = clk ^ rst_n ^ i_flush;
            assign o_tag       = i_tag;
        end else begin : g_pipe
            for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
                knap_tag_t w_src;
                knap_tag_t r_q;

                if (gi == 0) begin : g_head
                    assign w_src = i_tag;
                end else begin : g_body
                    assign w_src = g_stage[gi-1].r_q;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (i_flush) begin
                        r_q <= '0;
                    end else begin
                        r_q <= w_src;
                    end
                end
            end
            assign o_tag = g_stage[LAT-1].r_q;
        end
    endgenerate

endmodule

// File: rtl/knap_scan_ctrl.sv
// Sweeps every item-selection mask into the knapsack checker and collects the
// hit count plus the lowest and highest mask the checker accepted.
module knap_scan_ctrl
    import knap_pkg::*;
#(
    parameter int N_ITEMS = KNAP_N_ITEMS,
    parameter int CHK_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    knap_scan_ctrl_if.slave bus
);

    localparam logic [N_ITEMS-1:0] MASK_ALL = '1;

    scan_state_e        r_state, w_state_next;
    logic [N_ITEMS-1:0] r_cand, w_cand_next;
    logic [1:0]         r_drain_cnt, w_drain_next;
    logic               r_mode, w_mode_next;
    logic               r_found, w_found_next;
    logic               r_aborted, w_aborted_next;
    logic [N_ITEMS-1:0] r_first, w_first_next;
    logic [N_ITEMS-1:0] r_last, w_last_next;
    logic [CNT_W-1:0]   r_hits, w_hits_next;

    knap_tag_t          w_push_tag;
    knap_tag_t          w_pipe_tag;
    logic               w_flush;
    logic               w_hit;
    logic               w_active;

    // Only masks issued during SCAN are tagged valid; DRAIN/IDLE push bubbles.
    assign w_push_tag.issued = (r_state == ST_SCAN);
    assign w_push_tag.mask   = r_cand;
    assign w_active          = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
    assign w_hit             = w_pipe_tag.issued && bus.valid_in;

    knap_tag_pipe #(
        .LAT (CHK_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_tag   (w_push_tag),
        .o_tag   (w_pipe_tag)
    );

    always_comb begin
        w_state_next   = r_state;
        w_cand_next    = r_cand;
        w_drain_next   = r_drain_cnt;
        w_mode_next    = r_mode;
        w_found_next   = r_found;
        w_aborted_next = r_aborted;
        w_first_next   = r_first;
        w_last_next    = r_last;
        w_hits_next    = r_hits;
        w_flush        = 1'b0;

        if (w_hit) begin
            if (r_hits != '1) begin
                w_hits_next = r_hits + 1'b1;
            end
            w_last_next = w_pipe_tag.mask;
            if (!r_found) begin
                w_first_next = w_pipe_tag.mask;
                w_found_next = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next   = ST_SCAN;
                    w_cand_next    = '0;
                    w_mode_next    = bus.stop_on_first;
                    w_found_next   = 1'b0;
                    w_aborted_next = 1'b0;
                    w_hits_next    = '0;
                    w_first_next   = '0;
                    w_last_next    = '0;
                end
            end
            ST_SCAN: begin
                // The final mask is held rather than wrapping back to zero.
                if (r_cand == MASK_ALL) begin
                    w_state_next = (CHK_LAT == 0) ? ST_DONE : ST_DRAIN;
                    w_drain_next = '0;
                end else begin
                    w_cand_next = r_cand + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == 2'(CHK_LAT - 1)) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_drain_next = r_drain_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Abort and early stop both end the sweep and discard in-flight tags.
        if (w_active && (bus.abort || (r_mode && w_hit))) begin
            w_state_next = ST_DONE;
            w_flush      = 1'b1;
            if (bus.abort) begin
                w_aborted_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cand      <= '0;
            r_drain_cnt <= '0;
            r_mode      <= 1'b0;
            r_found     <= 1'b0;
            r_aborted   <= 1'b0;
            r_first     <= '0;
            r_last      <= '0;
            r_hits      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cand      <= w_cand_next;
            r_drain_cnt <= w_drain_next;
            r_mode      <= w_mode_next;
            r_found     <= w_found_next;
            r_aborted   <= w_aborted_next;
            r_first     <= w_first_next;
            r_last      <= w_last_next;
            r_hits      <= w_hits_next;
        end
    end

    assign bus.cand       = r_cand;
    assign bus.busy       = w_active;
    assign bus.done       = (r_state == ST_DONE);
    assign bus.aborted    = r_aborted;
    assign bus.found      = r_found;
    assign bus.first_mask = r_first;
    assign bus.last_mask  = r_last;
    assign bus.hit_count  = r_hits;

endmodule
